// File: rtl/xpb_table_gen.sv
// Runtime generator for a 2^IDX_BITS-entry XPB reduction table.
// Entry j = (j*B) mod M is built by repeated modular addition and streamed onto a RAM write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; modulus/base captured on acceptance
// S_WRITE | entry idx is on the write port (wr_en high)
// S_ADD   | acc <- (acc + b_r) mod m_r, idx <- idx + 1
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module xpb_table_gen #(
    parameter int WORD_LEN = 1024,
    parameter int IDX_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WORD_LEN-1:0] modulus,
    input  logic [WORD_LEN-1:0] base,
    output logic                busy,
    output logic                done,
    output logic                wr_en,
    output logic [IDX_BITS-1:0] wr_addr,
    output logic [WORD_LEN-1:0] wr_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [WORD_LEN-1:0] m_r, m_n;
    logic [WORD_LEN-1:0] b_r, b_n;
    logic [WORD_LEN-1:0] acc, acc_n;
    logic [IDX_BITS-1:0] idx, idx_n;

    logic                busy_n;
    logic                done_n;
    logic                wr_en_n;
    logic [IDX_BITS-1:0] wr_addr_n;
    logic [WORD_LEN-1:0] wr_data_n;

    // The carry out of acc + b_r must take part in the compare when M is near 2^WORD_LEN.
    logic [WORD_LEN:0]   sum;
    logic [WORD_LEN+1:0] diff;
    logic                sum_ge_m;
    logic [1:0]          unused_diff_msbs;

    assign sum              = {1'b0, acc} + {1'b0, b_r};
    assign diff             = {1'b0, sum} - {2'b00, m_r};
    assign sum_ge_m         = (sum >= {1'b0, m_r});
    assign unused_diff_msbs = diff[WORD_LEN+1:WORD_LEN];

    always_comb begin
        state_n = state;
        m_n     = m_r;
        b_n     = b_r;
        acc_n   = acc;
        idx_n   = idx;

        case (state)
            S_IDLE: begin
                if (start) begin
                    m_n     = modulus;
                    b_n     = base;
                    acc_n   = '0;
                    idx_n   = '0;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx == {IDX_BITS{1'b1}}) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_ADD;
                end
            end
            S_ADD: begin
                acc_n   = sum_ge_m ? diff[WORD_LEN-1:0] : sum[WORD_LEN-1:0];
                idx_n   = idx + 1'b1;
                state_n = S_WRITE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state presents.
        busy_n    = (state_n != S_IDLE);
        done_n    = (state_n == S_DONE);
        wr_en_n   = (state_n == S_WRITE);
        wr_addr_n = wr_en_n ? idx_n : wr_addr;
        wr_data_n = wr_en_n ? acc_n : wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            m_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            m_r     <= m_n;
            b_r     <= b_n;
            acc     <= acc_n;
            idx     <= idx_n;
            busy    <= busy_n;
            done    <= done_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: per-cycle capture of the write port, busy and done,
// checked against hand-derived tables and cycle positions.
module tb_xpb_table_gen;

    localparam int WL = 1024;
    localparam int IB = 5;
    localparam int NCAP = 256;

    logic          clk;
    logic          reset;
    logic          start;
    logic [WL-1:0] modulus;
    logic [WL-1:0] base;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic [IB-1:0] wr_addr;
    logic [WL-1:0] wr_data;

    xpb_table_gen #(.WORD_LEN(WL), .IDX_BITS(IB)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .modulus (modulus),
        .base    (base),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic          en_a   [NCAP];
    logic [IB-1:0] ad_a   [NCAP];
    logic [WL-1:0] dat_a  [NCAP];
    logic          busy_a [NCAP];
    logic          done_a [NCAP];
    logic [WL-1:0] exp_tab[32];
    logic [WL-1:0] m_big;

    task automatic chk(input string tag, input logic [WL-1:0] got, input logic [WL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Raises start so it is sampled at the next rising edge (cycle 0 of a run).
    task automatic begin_run(input logic [WL-1:0] m, input logic [WL-1:0] b);
        @(negedge clk);
        modulus = m;
        base    = b;
        start   = 1'b1;
    endtask

    // Records cycles 1..n; inputs for edge c are set after sampling cycle c.
    task automatic capture(input int n, input int pulse_cyc, input logic [WL-1:0] b2,
                           input int rst_cyc, input bit hold);
        for (int i = 0; i < NCAP; i++) begin
            en_a[i] = 0; ad_a[i] = '0; dat_a[i] = '0; busy_a[i] = 0; done_a[i] = 0;
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            en_a[c]   = wr_en;
            ad_a[c]   = wr_addr;
            dat_a[c]  = wr_data;
            busy_a[c] = busy;
            done_a[c] = done;
            start = hold || (c == pulse_cyc);
            if (c == pulse_cyc) base = b2;
            reset = (c == rst_cyc);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    // Checks one full run whose start was sampled at edge off.
    task automatic verify(input string nm, input int off);
        int n_en, n_busy, n_done_early;
        n_en = 0; n_busy = 0; n_done_early = 0;
        for (int j = 0; j < 32; j++) begin
            chk($sformatf("%s_en%0d", nm, j), 1024'(en_a[off+1+2*j]), 1024'(1));
            chk($sformatf("%s_addr%0d", nm, j), 1024'(ad_a[off+1+2*j]), 1024'(j));
            chk($sformatf("%s_data%0d", nm, j), dat_a[off+1+2*j], exp_tab[j]);
        end
        for (int c = off + 1; c <= off + 64; c++) begin
            if (en_a[c]) n_en++;
            if (busy_a[c]) n_busy++;
            if (done_a[c] && c != off + 64) n_done_early++;
        end
        chk({nm, "_wr_count"}, 1024'(n_en), 1024'(32));
        chk({nm, "_busy_count"}, 1024'(n_busy), 1024'(64));
        chk({nm, "_done_early"}, 1024'(n_done_early), 1024'(0));
        chk({nm, "_done_at64"}, 1024'(done_a[off+64]), 1024'(1));
        chk({nm, "_idle_at65"}, 1024'(busy_a[off+65]), 1024'(0));
    endtask

    task automatic fill_small(input int m, input int b);
        for (int j = 0; j < 32; j++) exp_tab[j] = 1024'((j * b) % m);
    endtask

    initial begin
        int n_tmp;
        reset   = 1'b1;
        start   = 1'b0;
        modulus = '0;
        base    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 1024'(busy), 1024'(0));
        chk("rst_done", 1024'(done), 1024'(0));
        chk("rst_wr_en", 1024'(wr_en), 1024'(0));
        chk("rst_wr_addr", 1024'(wr_addr), 1024'(0));
        chk("rst_wr_data", wr_data, '0);
        reset = 1'b0;

        // M=97, B=10: spot values 10, 90, 3, 19 appear in exp_tab[1,9,10,31]
        fill_small(97, 10);
        chk("m97_spot31", exp_tab[31], 1024'(19));
        begin_run(1024'(97), 1024'(10));
        capture(70, -1, '0, -1, 0);
        verify("m97", 0);
        chk("m97_addr10", dat_a[21], 1024'(3));
        chk("m97_addr9", dat_a[19], 1024'(90));

        // Carry path: M = 2^1024-3, B = M-1 gives entry j = M-j
        m_big = {WL{1'b1}} - 1024'd2;
        exp_tab[0] = '0;
        for (int j = 1; j < 32; j++) exp_tab[j] = m_big - 1024'(j);
        begin_run(m_big, m_big - 1024'd1);
        capture(70, -1, '0, -1, 0);
        verify("carry", 0);
        n_tmp = 0;
        for (int j = 0; j < 32; j++) if (dat_a[1+2*j] >= m_big) n_tmp++;
        chk("carry_all_lt_m", 1024'(n_tmp), 1024'(0));

        // B = 0: all entries zero
        for (int j = 0; j < 32; j++) exp_tab[j] = '0;
        begin_run(1024'(97), 1024'(0));
        capture(70, -1, '0, -1, 0);
        verify("b0", 0);

        // Second start while busy is ignored; base change is not picked up
        fill_small(97, 10);
        begin_run(1024'(97), 1024'(10));
        capture(140, 10, 1024'(5), -1, 0);
        verify("ignore", 0);
        n_tmp = 0;
        for (int c = 1; c <= 140; c++) if (done_a[c]) n_tmp++;
        chk("ignore_single_done", 1024'(n_tmp), 1024'(1));

        // Reset mid-run at cycle 20, then a fresh start at cycle 25
        begin_run(1024'(97), 1024'(10));
        capture(24, -1, '0, 20, 0);
        n_tmp = 0;
        for (int c = 21; c <= 24; c++) if (en_a[c] || busy_a[c] || done_a[c]) n_tmp++;
        chk("rstmid_quiet", 1024'(n_tmp), 1024'(0));
        n_tmp = 0;
        for (int c = 1; c <= 20; c++) if (en_a[c]) n_tmp++;
        chk("rstmid_writes_before", 1024'(n_tmp), 1024'(10));
        chk("rstmid_addr_cleared", 1024'(ad_a[21]), 1024'(0));
        chk("rstmid_data_cleared", dat_a[21], '0);
        begin_run(1024'(97), 1024'(10));
        capture(70, -1, '0, -1, 0);
        verify("after_rst", 0);

        // start held high: back-to-back runs, done at 64 and 129
        begin_run(1024'(97), 1024'(10));
        capture(200, -1, '0, -1, 1);
        verify("b2b_run1", 0);
        verify("b2b_run2", 65);
        chk("b2b_done129", 1024'(done_a[129]), 1024'(1));
        chk("b2b_first_write66", 1024'(en_a[66]), 1024'(1));
        n_tmp = 0;
        for (int c = 1; c <= 130; c++) if (done_a[c]) n_tmp++;
        chk("b2b_done_count", 1024'(n_tmp), 1024'(2));

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("final_idle", 1024'(busy), 1024'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Sequential generator that fills a 32-entry XPB reduction table at runtime instead of hard-coding it. Given a modulus M and a base value B (B = 2^k mod M for the table's bit position), it produces entry j = (j·B) mod M for j = 0..31 by repeated modular addition. Each entry is emitted on a write port into the table RAM that the modular-square datapath reads by 5-bit chunk index. One instance rebuilds one table per start, so the design can load a new modulus without resynthesis.

## Interface
- `WORD_LEN`, default 1024, width of the modulus, base and table entries.
- `IDX_BITS`, default 5, table index width; the table has 2^IDX_BITS entries.

- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request table generation; sampled only in IDLE.
- `modulus` input WORD_LEN: M, captured on an accepted start; odd, nonzero.
- `base` input WORD_LEN: B, captured on an accepted start; precondition B < M.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last entry is written.
- `wr_en` output 1: table write strobe.
- `wr_addr` output IDX_BITS: table index j.
- `wr_data` output WORD_LEN: entry value (j·B) mod M.

## Operation
- States are IDLE, WRITE, ADD and DONE.
- **IDLE**
  - On start=1: latch M→m_r and B→b_r, clear acc=0 and idx=0, then go to WRITE.
  - Otherwise stay in IDLE.
- **WRITE**
  - Drive wr_en=1, wr_addr=idx, wr_data=acc.
  - If idx == 2^IDX_BITS−1, go to DONE; else go to ADD.
- **ADD**
  - sum = acc + b_r, computed WORD_LEN+1 bits wide so the carry is kept.
  - diff = sum − m_r, computed WORD_LEN+2 bits wide.
  - acc ← (sum ≥ m_r) ? diff[WORD_LEN-1:0] : sum[WORD_LEN-1:0].
  - idx ← idx+1, then go to WRITE.
  - A single conditional subtraction is sufficient because acc < M and b_r < M.
- **DONE**: done=1 for this cycle, then go to IDLE.
- start is ignored in WRITE, ADD and DONE. Latched m_r and b_r are stable for the whole run, even if the inputs change.
- If B ≥ M, the output values are undefined, but the sequencing (addresses, cycle counts, done) is unchanged.
- Entry 0 is always 0.

## Timing
- Registered outputs. Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE.
- wr_addr and wr_data hold their last values when wr_en=0; only wr_en is qualifying.
- Cycle numbering: start is sampled high at edge 0.
  - Entry j is written in cycle 1+2j (j = 0..31), and wr_en is high only in odd cycles 1..63.
  - done is high in cycle 64.
  - busy is high in cycles 1..64.
  - IDLE resumes in cycle 65, and a start sampled at edge 65 is accepted.
- Total: 64 busy cycles per table; 32 writes in strictly ascending address order with no repeats.
- A start held high continuously restarts generation one cycle after each done (back-to-back runs).
- reset asserted in any state: at the next edge the block returns to IDLE, all outputs take their reset values, and no further writes or done occur. A partially written table is left as is.
- reset and start high in the same cycle: reset wins.
- Carry path: sum can exceed 2^WORD_LEN when M is close to 2^WORD_LEN, and the comparison must use the full WORD_LEN+1-bit sum.

## Test plan
- M=97, B=10 → writes j·10 mod 97: addr1=10, addr9=90, addr10=3, addr31=19. done in cycle 64, busy cycles 1..64, exactly 32 wr_en pulses.
- M=2^1024−3, B=M−1 (carry path) → addr0=0, addr1=M−1, addr2=M−2, addr31=M−31. Every entry must be < M.
- B=0, M=97 → all 32 entries 0, timing identical to the first scenario.
- Start with M=97, B=10, then pulse start again at cycle 10 with B=5 while busy → second start ignored, entries still j·10 mod 97, single done.
- Assert reset for one cycle at cycle 20 mid-run → from cycle 21 wr_en=0, busy=0, done never pulses. A new start at cycle 25 produces a full correct table with done 64 cycles later.
- start held high for 200 cycles with M=97, B=10 → done at cycles 64 and 129. Second run's first write at cycle 66, and acc restarts from 0.
